// File: rtl/vis_fetch_if.sv
// Wishbone-classic read port between the SPI bus master and the visibility fetch stage.
// The SPI slave drives the request side, and the fetch stage returns the ack and the cached visibility.
interface vis_fetch_if #(
  parameter int WIDTH = 32
);
  logic             cyc_i;
  logic             stb_i;
  logic             we_i;
  logic [15:0]      adr_i;
  logic             ack_o;
  logic [WIDTH-1:0] real_o;
  logic [WIDTH-1:0] imag_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i,
    output ack_o, real_o, imag_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i,
    input  ack_o, real_o, imag_o
  );
endinterface

// File: rtl/vis_fetch.sv
// Visibility read-out stage: serves Wishbone reads from the double-banked correlator SRAM
// through a one-entry cache, and owns the bank-swap handshake with the correlator.
module vis_fetch #(
  parameter int ABITS = 13,
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  vis_fetch_if.slave         wb,
  output logic               sram_rd_o,
  output logic [ABITS:0]     sram_adr_o,
  input  logic [2*WIDTH-1:0] sram_dat_i,
  input  logic               swap_req_i,
  output logic               swap_ack_o,
  output logic               bank_o,
  output logic               avail_o,
  output logic               overrun_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ACK
  } state_t;

  state_t           state;
  logic             pending;
  logic             tag_valid;
  logic [ABITS-1:0] tag;

  logic [ABITS-1:0] idx;
  logic             req;
  logic             hit;
  logic             do_swap;

  assign idx     = wb.adr_i[ABITS-1:0];
  assign req     = wb.cyc_i && wb.stb_i;
  assign hit     = tag_valid && (tag == idx);
  // The frame may only flip between bus cycles, so the host never sees a torn frame.
  assign do_swap = (state == S_IDLE) && pending && !wb.cyc_i;

  // NOTE: every register is assigned with <= so all updates take effect together at the clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wb.ack_o   <= 1'b0;
      wb.real_o  <= '0;
      wb.imag_o  <= '0;
      sram_rd_o  <= 1'b0;
      sram_adr_o <= '0;
      swap_ack_o <= 1'b0;
      bank_o     <= 1'b0;
      avail_o    <= 1'b0;
      overrun_o  <= 1'b0;
      pending    <= 1'b0;
      tag_valid  <= 1'b0;
      tag        <= '0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only where a branch needs them.
      wb.ack_o   <= 1'b0;
      sram_rd_o  <= 1'b0;
      swap_ack_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (do_swap) begin
            state <= S_IDLE;
          end else if (req && wb.we_i) begin
            // A write is the host's "frame consumed" acknowledgement.
            wb.ack_o  <= 1'b1;
            avail_o   <= 1'b0;
            overrun_o <= 1'b0;
            state     <= S_ACK;
          end else if (req && hit) begin
            wb.ack_o <= 1'b1;
            state    <= S_ACK;
          end else if (req) begin
            sram_rd_o  <= 1'b1;
            sram_adr_o <= {bank_o, idx};
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          wb.real_o <= sram_dat_i[2*WIDTH-1:WIDTH];
          wb.imag_o <= sram_dat_i[WIDTH-1:0];
          tag       <= sram_adr_o[ABITS-1:0];
          tag_valid <= 1'b1;
          wb.ack_o  <= 1'b1;
          state     <= S_ACK;
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Placed after the bus case so a request arriving alongside a frame-consumed write still flags overrun.
      if (do_swap) begin
        bank_o     <= ~bank_o;
        tag_valid  <= 1'b0;
        avail_o    <= 1'b1;
        swap_ack_o <= 1'b1;
        pending    <= swap_req_i;
      end else if (swap_req_i) begin
        if (pending) begin
          overrun_o <= 1'b1;
        end
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vis_fetch.sv
// Self-checking bench for vis_fetch: table-driven reads with a scoreboard queue, plus
// hand-written sequences for bank swaps, overrun, frame-consumed writes and reset in LATCH.
module tb_vis_fetch;
  localparam int ABITS = 13;
  localparam int WIDTH = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vis_fetch_if #(.WIDTH(WIDTH)) wb ();

  logic               sram_rd_o;
  logic [ABITS:0]     sram_adr_o;
  logic [2*WIDTH-1:0] sram_dat_i;
  logic               swap_req_i = 1'b0;
  logic               swap_ack_o;
  logic               bank_o;
  logic               avail_o;
  logic               overrun_o;

  vis_fetch #(.ABITS(ABITS), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wb         (wb),
    .sram_rd_o  (sram_rd_o),
    .sram_adr_o (sram_adr_o),
    .sram_dat_i (sram_dat_i),
    .swap_req_i (swap_req_i),
    .swap_ack_o (swap_ack_o),
    .bank_o     (bank_o),
    .avail_o    (avail_o),
    .overrun_o  (overrun_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM contents: bank0[5] is the documented test word, everything else encodes {bank, idx}.
  function automatic logic [63:0] sram_val(input logic bank, input logic [12:0] idx);
    if (!bank && idx == 13'd5) return {32'h1122_3344, 32'h5566_7788};
    return {8'hC0, 7'd0, bank, 3'd0, idx, 8'h3E, 7'd0, ~bank, 3'd0, ~idx};
  endfunction

  // Data is valid exactly one cycle after the read strobe; any other cycle carries junk.
  always @(posedge clock) begin
    if (sram_rd_o) sram_dat_i <= sram_val(sram_adr_o[ABITS], sram_adr_o[ABITS-1:0]);
    else           sram_dat_i <= {$urandom(), $urandom()};
  end

  int   swap_acks   = 0;
  int   ack_count   = 0;
  int   bank_glitch = 0;
  bit   watch_bank  = 1'b0;
  logic watch_val   = 1'b0;

  always @(negedge clock) begin
    if (swap_ack_o === 1'b1) swap_acks++;
    if (wb.ack_o === 1'b1) ack_count++;
    if (watch_bank && wb.cyc_i && bank_o !== watch_val) bank_glitch++;
  end

  typedef struct {
    logic [63:0] data;
    int          lat;
    bit          rd;
  } exp_t;
  exp_t sb[$];

  logic        exp_bank = 1'b0;
  logic [63:0] cur_data = '0;

  // Entered and left on a falling edge with the DUT back in IDLE.
  task automatic do_xfer(input logic [2:0] lane, input logic [12:0] idx, input logic we,
                         input bit hit, input bit keep_cyc, input string name);
    exp_t        e;
    int          lat;
    bit          saw_rd;
    bit          got_ack;
    logic [13:0] rd_adr;
    e.rd   = !(we || hit);
    e.lat  = e.rd ? 3 : 1;
    e.data = e.rd ? sram_val(exp_bank, idx) : cur_data;
    sb.push_back(e);

    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.we_i  = we;
    wb.adr_i = {lane, idx};
    lat     = 0;
    saw_rd  = 1'b0;
    got_ack = 1'b0;
    rd_adr  = '0;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(negedge clock);
      lat++;
      if (sram_rd_o === 1'b1) begin
        saw_rd = 1'b1;
        rd_adr = sram_adr_o;
      end
      if (wb.ack_o === 1'b1) got_ack = 1'b1;
    end
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
    if (!keep_cyc) wb.cyc_i = 1'b0;

    e = sb.pop_front();
    if (!got_ack) begin
      check({name, " ack timeout"}, 64'(got_ack), 64'd1);
    end else begin
      check({name, " latency"}, 64'(lat), 64'(e.lat));
      check({name, " sram_rd"}, 64'(saw_rd), 64'(e.rd));
      if (e.rd) check({name, " sram_adr"}, 64'(rd_adr), 64'({exp_bank, idx}));
      check({name, " data"}, {wb.real_o, wb.imag_o}, e.data);
      cur_data = e.data;
    end
    @(negedge clock);
  endtask

  typedef struct {
    logic [2:0]  lane;
    logic [12:0] idx;
    logic        we;
    bit          hit;
  } vec_t;

  vec_t vecs[8];
  int   acks_before;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
    wb.adr_i = '0;

    vecs[0] = '{3'd0, 13'd5,      1'b0, 1'b0};
    vecs[1] = '{3'd6, 13'd5,      1'b0, 1'b1};
    vecs[2] = '{3'd0, 13'd7,      1'b0, 1'b0};
    vecs[3] = '{3'd3, 13'd7,      1'b0, 1'b1};
    vecs[4] = '{3'd0, 13'd5,      1'b0, 1'b0};
    vecs[5] = '{3'd0, 13'h1FFF,   1'b0, 1'b0};
    vecs[6] = '{3'd7, 13'h1FFF,   1'b0, 1'b1};
    vecs[7] = '{3'd0, 13'd0,      1'b0, 1'b0};

    // Reset values
    repeat (2) @(negedge clock);
    check("reset ack", 64'(wb.ack_o), 64'd0);
    check("reset data", {wb.real_o, wb.imag_o}, 64'd0);
    check("reset sram", 64'({sram_rd_o, sram_adr_o}), 64'd0);
    check("reset swap flags", 64'({swap_ack_o, bank_o, avail_o, overrun_o}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Reads in bank 0, served although no frame is available yet
    foreach (vecs[i])
      do_xfer(vecs[i].lane, vecs[i].idx, vecs[i].we, vecs[i].hit, 1'b0, $sformatf("vec%0d", i));

    // Swap with the bus idle: pending is set at the first edge, the swap lands at the next
    swap_req_i = 1'b1;
    @(negedge clock);
    swap_req_i = 1'b0;
    @(negedge clock);
    check("idle swap flags", 64'({bank_o, swap_ack_o, avail_o, overrun_o}), 64'b1110);
    @(negedge clock);
    check("idle swap ack pulse", 64'(swap_ack_o), 64'd0);
    exp_bank = 1'b1;
    do_xfer(3'd0, 13'd5, 1'b0, 1'b0, 1'b0, "bank1 reread");

    // Swap request during an 8-read burst: bank frozen until cyc_i falls
    watch_val  = 1'b1;
    watch_bank = 1'b1;
    fork
      begin
        do_xfer(3'd0, 13'd20, 1'b0, 1'b0, 1'b1, "burst0");
        do_xfer(3'd1, 13'd20, 1'b0, 1'b1, 1'b1, "burst1");
        do_xfer(3'd0, 13'd21, 1'b0, 1'b0, 1'b1, "burst2");
        do_xfer(3'd0, 13'd22, 1'b0, 1'b0, 1'b1, "burst3");
        do_xfer(3'd2, 13'd22, 1'b0, 1'b1, 1'b1, "burst4");
        do_xfer(3'd0, 13'd23, 1'b0, 1'b0, 1'b1, "burst5");
        do_xfer(3'd0, 13'd24, 1'b0, 1'b0, 1'b1, "burst6");
        do_xfer(3'd0, 13'd25, 1'b0, 1'b0, 1'b1, "burst7");
      end
      begin
        repeat (5) @(negedge clock);
        swap_req_i = 1'b1;
        @(negedge clock);
        swap_req_i = 1'b0;
      end
    join
    watch_bank = 1'b0;
    check("burst bank stable", 64'(bank_glitch), 64'd0);
    check("burst no swap yet", 64'({bank_o, swap_ack_o, overrun_o}), 64'b100);
    wb.cyc_i = 1'b0;
    @(negedge clock);
    check("post-burst swap", 64'({swap_ack_o, bank_o}), 64'b10);
    exp_bank = 1'b0;
    @(negedge clock);

    // Two requests 3 cycles apart while cyc_i is held: overrun, one swap only
    wb.cyc_i = 1'b1;
    swap_req_i = 1'b1;
    @(negedge clock);
    swap_req_i = 1'b0;
    repeat (2) @(negedge clock);
    swap_req_i = 1'b1;
    @(negedge clock);
    swap_req_i = 1'b0;
    @(negedge clock);
    check("overrun set", 64'({overrun_o, bank_o}), 64'b10);
    acks_before = swap_acks;
    wb.cyc_i = 1'b0;
    @(negedge clock);
    check("overrun swap", 64'({swap_ack_o, bank_o}), 64'b11);
    repeat (4) @(negedge clock);
    check("single swap", 64'(swap_acks - acks_before), 64'd1);
    check("single swap bank", 64'(bank_o), 64'd1);
    exp_bank = 1'b1;

    // Frame-consumed write clears avail and overrun, ack in cycle 1
    check("avail before write", 64'(avail_o), 64'd1);
    do_xfer(3'd0, 13'd0, 1'b1, 1'b0, 1'b0, "write");
    check("write clears flags", 64'({avail_o, overrun_o}), 64'b00);

    // Reset in LATCH: immediate reset values, no ack, and the cache is forgotten
    do_xfer(3'd0, 13'd9, 1'b0, 1'b0, 1'b0, "cache idx9");
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.we_i  = 1'b0;
    wb.adr_i = {3'd0, 13'd11};
    @(negedge clock);
    check("pre-reset fetch", 64'({sram_rd_o, sram_adr_o}), 64'({1'b1, 1'b1, 13'd11}));
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("async reset outputs",
          64'({wb.ack_o, sram_rd_o, sram_adr_o, swap_ack_o, bank_o, avail_o, overrun_o}), 64'd0);
    check("async reset data", {wb.real_o, wb.imag_o}, 64'd0);
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    acks_before = ack_count;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("no ack after reset", 64'(ack_count - acks_before), 64'd0);
    exp_bank = 1'b0;
    cur_data = '0;
    do_xfer(3'd0, 13'd11, 1'b0, 1'b0, 1'b0, "post-reset idx11");
    do_xfer(3'd0, 13'd9, 1'b0, 1'b0, 1'b0, "post-reset idx9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
